// File: rtl/instr_fetch.sv
// instr_fetch -- fetch stage feeding the execute stage.
//
// Holds the PC and issues single-word reads to instruction memory. At most
// one read is outstanding at a time. Returned words are buffered, together
// with their addresses, in a 2-entry FIFO and are presented to execute over
// a valid/ready handshake. A redirect flushes the FIFO and restarts fetching
// at redirect_pc. A response that was already in flight when the redirect
// happened is dropped. halt only stops new requests. The outstanding response
// still lands in the FIFO, and the FIFO keeps draining.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   halt            1 = issue no new memory requests
//   redirect        1-cycle pulse: flush and restart at redirect_pc
//   redirect_pc     new fetch address
//   mem_req         1-cycle read request pulse (registered)
//   mem_addr        word address, valid with mem_req
//   mem_rsp_valid   read data valid, at least 1 cycle after mem_req
//   mem_rsp_data    returned instruction word
//   instr_valid     FIFO head holds an instruction
//   instr_ready     execute accepts the head this cycle
//   instruction     FIFO head instruction
//   instr_pc        address of the head instruction
module instr_fetch #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] instr_pc
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DISCARD
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;

  logic [DATA_W-1:0] fifo_data [2];
  logic [ADDR_W-1:0] fifo_pc   [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;
  logic [1:0]        count_after;

  logic              pop;
  logic              rsp_live;
  logic              push;
  logic              issue;

  assign instr_valid = (count != 2'd0);
  assign instruction = fifo_data[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];

  assign pop      = instr_valid & instr_ready;
  assign rsp_live = (state == ST_WAIT) & mem_rsp_valid;
  assign push     = rsp_live & ~redirect;

  // Occupancy once this cycle's push/pop settle. A new request is issued only
  // if its own response is guaranteed a free slot, even if nothing pops.
  assign count_after = count + {1'b0, push} - {1'b0, pop};

  assign issue = ((state == ST_IDLE) | rsp_live) & ~halt & ~redirect &
                 (count_after <= 2'd1);

  always_comb begin
    state_nxt = state;
    if (redirect) begin
      // A read still in flight must be swallowed when it returns.
      if ((state != ST_IDLE) && !mem_rsp_valid)
        state_nxt = ST_DISCARD;
      else
        state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:    if (issue) state_nxt = ST_WAIT;
        ST_WAIT:    if (mem_rsp_valid) state_nxt = issue ? ST_WAIT : ST_IDLE;
        ST_DISCARD: if (mem_rsp_valid) state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      pc           <= RESET_PC;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= 2'd0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_pc[0]   <= '0;
      fifo_pc[1]   <= '0;
    end else begin
      state   <= state_nxt;
      mem_req <= issue;

      if (redirect) begin
        pc     <= redirect_pc;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (issue) begin
          // mem_addr holds the outstanding address until the next issue,
          // so it doubles as the tag for the returning word.
          mem_addr <= pc;
          pc       <= pc + ADDR_W'(1);
        end
        if (pop)
          rd_ptr <= ~rd_ptr;
        if (push) begin
          fifo_data[wr_ptr] <= mem_rsp_data;
          fifo_pc[wr_ptr]   <= mem_addr;
          wr_ptr            <= ~wr_ptr;
        end
        count <= count_after;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch -- self-checking bench for instr_fetch.
//
// A behavioural model (queues plus a few flags) predicts mem_req/mem_addr and
// the FIFO head every cycle. A memory responder replies to each request after
// a chosen latency. Directed phases cover streaming, back-pressure, redirect
// with a stale response, PC wrap, halt and mid-flight reset. A randomized
// phase follows.
module tb_instr_fetch;

  localparam int unsigned AW     = 16;
  localparam int unsigned DW     = 32;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          halt = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_rsp_valid = 1'b0;
  logic [DW-1:0] mem_rsp_data = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [DW-1:0] instruction;
  logic [AW-1:0] instr_pc;

  instr_fetch #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .RESET_PC(RST_PC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .halt         (halt),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instruction  (instruction),
    .instr_pc     (instr_pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_req;
  logic [15:0] m_addr;
  logic [15:0] m_pc;
  bit          m_busy;      // a read is in flight
  bit          m_drop;      // the in-flight read belongs to a flushed stream
  logic [15:0] m_out_addr;
  logic [31:0] q_data[$];
  logic [15:0] q_pc[$];

  task automatic model_reset();
    m_req  = 0;
    m_addr = '0;
    m_pc   = RST_PC;
    m_busy = 0;
    m_drop = 0;
    m_out_addr = '0;
    q_data.delete();
    q_pc.delete();
  endtask

  task automatic model_step(input bit h, input bit r, input logic [15:0] rpc,
                            input bit rdy, input bit rv, input logic [31:0] rd);
    bit pop, live, resp_done, free_now, iss;
    if (r) begin
      q_data.delete();
      q_pc.delete();
      m_pc = rpc;
      if (m_busy && !rv) m_drop = 1;
      else begin
        m_busy = 0;
        m_drop = 0;
      end
      m_req = 0;
    end else begin
      pop       = (q_pc.size() != 0) && rdy;
      live      = m_busy && !m_drop && rv;
      resp_done = m_busy && rv;
      if (pop) begin
        void'(q_data.pop_front());
        void'(q_pc.pop_front());
      end
      if (live) begin
        q_data.push_back(rd);
        q_pc.push_back(m_out_addr);
      end
      free_now = !m_busy || live;
      iss = free_now && !h && (q_pc.size() + 1 <= 2);
      if (resp_done) begin
        m_busy = 0;
        m_drop = 0;
      end
      m_req = iss;
      if (iss) begin
        m_addr     = m_pc;
        m_out_addr = m_pc;
        m_pc       = m_pc + 16'd1;
        m_busy     = 1;
      end
    end
  endtask

  task automatic check_outputs();
    cmp("mem_req", 32'(mem_req), 32'(m_req));
    if (m_req) cmp("mem_addr", 32'(mem_addr), 32'(m_addr));
    cmp("instr_valid", 32'(instr_valid), 32'(q_pc.size() != 0));
    if (q_pc.size() != 0) begin
      cmp("instruction", instruction, q_data[0]);
      cmp("instr_pc", 32'(instr_pc), 32'(q_pc[0]));
    end
  endtask

  // ---------------- stimulus / memory ----------------
  bit          st_halt, st_redir, st_ready, st_spur;
  logic [15:0] st_rpc;
  int          st_lat = 1;
  int          tmr = 0;
  logic [15:0] raddr = '0;
  int unsigned seq = 0;
  logic [15:0] req_log[$];
  logic [15:0] pop_log[$];
  bit          saw_valid;

  task automatic tick();
    logic        rv;
    logic [31:0] rd;
    @(negedge clk);
    check_outputs();
    if (mem_req) req_log.push_back(mem_addr);
    if (instr_valid && st_ready) pop_log.push_back(instr_pc);
    if (instr_valid) saw_valid = 1;
    rv = 1'b0;
    rd = '0;
    if (tmr > 0) begin
      tmr--;
      if (tmr == 0) begin
        rv = 1'b1;
        rd = {seq[15:0], raddr};
      end
    end else if (st_spur && !m_busy) begin
      rv = 1'b1;
      rd = $urandom;
    end
    if (mem_req) begin
      tmr   = st_lat;
      raddr = mem_addr;
      seq++;
    end
    halt          = st_halt;
    redirect      = st_redir;
    redirect_pc   = st_rpc;
    instr_ready   = st_ready;
    mem_rsp_valid = rv;
    mem_rsp_data  = rd;
    model_step(st_halt, st_redir, st_rpc, st_ready, rv, rd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    halt = 1'b0;
    redirect = 1'b0;
    instr_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    cmp("rst_mem_req", 32'(mem_req), 32'd0);
    cmp("rst_mem_addr", 32'(mem_addr), 32'd0);
    cmp("rst_instr_valid", 32'(instr_valid), 32'd0);
    cmp("rst_instruction", instruction, 32'd0);
    cmp("rst_instr_pc", 32'(instr_pc), 32'd0);
    model_reset();
    tmr = 0;
    st_halt = 0; st_redir = 0; st_ready = 0; st_spur = 0; st_rpc = '0; st_lat = 1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    req_log.delete();
    pop_log.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // P1: stream with 1-cycle memory
    do_reset();
    st_ready = 1; st_lat = 1;
    for (int i = 0; i < 40 && pop_log.size() < 3; i++) tick();
    cmp("p1_pops_seen", 32'(pop_log.size() >= 3), 32'd1);
    if (pop_log.size() >= 3) begin
      cmp("p1_req0", 32'(req_log[0]), 32'h0000);
      cmp("p1_req1", 32'(req_log[1]), 32'h0001);
      cmp("p1_pc0", 32'(pop_log[0]), 32'h0000);
      cmp("p1_pc1", 32'(pop_log[1]), 32'h0001);
      cmp("p1_pc2", 32'(pop_log[2]), 32'h0002);
    end

    // P2: back-pressure holds exactly two entries
    do_reset();
    st_ready = 0; st_lat = 1;
    repeat (12) tick();
    cmp("p2_req_count", 32'(req_log.size()), 32'd2);
    cmp("p2_held_valid", 32'(instr_valid), 32'd1);
    req_log.delete();
    pop_log.delete();
    st_ready = 1;
    for (int i = 0; i < 10 && req_log.size() == 0; i++) tick();
    cmp("p2_resume_seen", 32'(req_log.size() != 0), 32'd1);
    if (req_log.size() != 0) cmp("p2_resume_addr", 32'(req_log[0]), 32'h0002);
    if (pop_log.size() >= 2) begin
      cmp("p2_pop0", 32'(pop_log[0]), 32'h0000);
      cmp("p2_pop1", 32'(pop_log[1]), 32'h0001);
    end

    // P3: redirect while the read of 0x0005 is outstanding
    do_reset();
    st_ready = 1; st_lat = 3;
    for (int i = 0; i < 100 && !(req_log.size() != 0 && req_log[req_log.size()-1] == 16'h0005); i++)
      tick();
    cmp("p3_req5_seen", 32'(req_log.size() != 0 && req_log[req_log.size()-1] == 16'h0005), 32'd1);
    st_redir = 1; st_rpc = 16'h0100;
    tick();
    st_redir = 0;
    pop_log.delete();
    for (int i = 0; i < 40 && pop_log.size() == 0; i++) tick();
    cmp("p3_pop_seen", 32'(pop_log.size() != 0), 32'd1);
    if (pop_log.size() != 0) cmp("p3_first_pc", 32'(pop_log[0]), 32'h0100);

    // P4: wrap from 0xFFFF to 0x0000
    st_lat = 2; st_ready = 1;
    st_redir = 1; st_rpc = 16'hFFFF;
    tick();
    st_redir = 0;
    req_log.delete();
    pop_log.delete();
    for (int i = 0; i < 60 && pop_log.size() < 2; i++) tick();
    cmp("p4_pops_seen", 32'(pop_log.size() >= 2), 32'd1);
    if (pop_log.size() >= 2) begin
      cmp("p4_req0", 32'(req_log[0]), 32'h0000FFFF);
      cmp("p4_req1", 32'(req_log[1]), 32'h00000000);
      cmp("p4_pc0", 32'(pop_log[0]), 32'h0000FFFF);
      cmp("p4_pc1", 32'(pop_log[1]), 32'h00000000);
    end

    // P5: halt with one read outstanding
    st_lat = 3; st_ready = 1;
    req_log.delete();
    for (int i = 0; i < 20 && req_log.size() == 0; i++) tick();
    cmp("p5_req_seen", 32'(req_log.size() != 0), 32'd1);
    st_halt = 1;
    req_log.delete();
    saw_valid = 0;
    repeat (12) tick();
    cmp("p5_no_req_in_halt", 32'(req_log.size()), 32'd0);
    cmp("p5_rsp_enqueued", 32'(saw_valid), 32'd1);
    st_halt = 0;
    for (int i = 0; i < 10 && req_log.size() == 0; i++) tick();
    cmp("p5_resume", 32'(req_log.size() != 0), 32'd1);

    // P6: reset while a read is in flight and the FIFO holds data
    st_ready = 0; st_lat = 3;
    for (int i = 0; i < 40 && !(m_busy && q_pc.size() >= 1); i++) tick();
    cmp("p6_setup", 32'(m_busy && q_pc.size() >= 1), 32'd1);
    do_reset();
    st_ready = 1; st_lat = 1; st_spur = 1;   // late response from before reset
    tick();
    st_spur = 0;
    for (int i = 0; i < 10 && req_log.size() == 0; i++) tick();
    cmp("p6_req_seen", 32'(req_log.size() != 0), 32'd1);
    if (req_log.size() != 0) cmp("p6_first_addr", 32'(req_log[0]), 32'(RST_PC));

    // P7: randomized traffic
    for (int i = 0; i < 3000; i++) begin
      st_halt  = ($urandom_range(0, 9) == 0);
      st_redir = ($urandom_range(0, 19) == 0);
      st_rpc   = ($urandom_range(0, 3) == 0) ? (16'hFFFE + 16'($urandom_range(0, 1)))
                                              : 16'($urandom);
      st_ready = ($urandom_range(0, 9) < 6);
      st_spur  = ($urandom_range(0, 9) == 0);
      st_lat   = $urandom_range(1, 3);
      tick();
    end
    st_halt = 0; st_redir = 0; st_spur = 0; st_ready = 1;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
